// File: rtl/audio_interp_stereo.sv
`default_nettype none
// ============================================================================
//  Module      : audio_interp_stereo
//  Description : Stereo sample-rate expander: FIFO-buffered linear
//                interpolation to offset-binary DAC codes, idle silence ramp.
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_interp_stereo #(
    parameter int PERIOD_LOG2    = 9,
    parameter int FIFO_LOG2      = 2,
    parameter int UNDERRUN_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in_l,
    input  logic [15:0] in_r,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] d_l,
    output logic [15:0] d_r,
    output logic        sample_tick,
    output logic        underrun
);
    localparam int SW = $clog2(UNDERRUN_LIMIT + 1);
    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam logic [FIFO_LOG2:0] C_FULL_COUNT = {1'b1, {FIFO_LOG2{1'b0}}};
    localparam logic [FIFO_LOG2:0] C_ONE        = {{FIFO_LOG2{1'b0}}, 1'b1};
    localparam logic [SW-1:0]      C_STARVE_LAST = SW'(UNDERRUN_LIMIT - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    logic [31:0]            mem_q [DEPTH];
    logic [FIFO_LOG2-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_LOG2:0]     count_q, count_d;
    logic [PERIOD_LOG2-1:0] phase_q, phase_d;
    state_t                 state_q, state_d;
    logic [SW-1:0]          starve_q, starve_d;
    logic [15:0]            prev_q [2];
    logic [15:0]            prev_d [2];
    logic [15:0]            cur_q  [2];
    logic [15:0]            cur_d  [2];
    logic [15:0]            dout_q [2];
    logic [15:0]            dout_d [2];
    logic                   tick_pend_q, tick_pend_d;
    logic                   sample_tick_q, sample_tick_d;
    logic                   underrun_q, underrun_d;

    logic                   w_wrap;
    logic                   w_push;
    logic [1:0]             w_pop_cnt;
    logic [FIFO_LOG2-1:0]   w_rd_ptr_nx;
    logic [31:0]            w_head;
    logic [31:0]            w_head1;

    assign in_ready    = (count_q != C_FULL_COUNT);
    assign w_push      = in_valid & in_ready;
    assign w_wrap      = &phase_q;
    assign w_rd_ptr_nx = rd_ptr_q + 1'b1;
    assign w_head      = mem_q[rd_ptr_q];
    assign w_head1     = mem_q[w_rd_ptr_nx];

    // Storage has no reset; only pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {in_l, in_r};
        end
    end

    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        prev_d     = prev_q;
        cur_d      = cur_q;
        w_pop_cnt  = 2'd0;
        underrun_d = 1'b0;
        if (w_wrap) begin
            if (state_q == ST_IDLE) begin
                if (count_q > C_ONE) begin
                    prev_d[0] = w_head[31:16];
                    prev_d[1] = w_head[15:0];
                    cur_d[0]  = w_head1[31:16];
                    cur_d[1]  = w_head1[15:0];
                    w_pop_cnt = 2'd2;
                    starve_d  = '0;
                    state_d   = ST_RUN;
                end else begin
                    prev_d   = cur_q;
                    cur_d[0] = '0;
                    cur_d[1] = '0;
                end
            end else begin
                prev_d = cur_q;
                if (count_q != '0) begin
                    cur_d[0]  = w_head[31:16];
                    cur_d[1]  = w_head[15:0];
                    w_pop_cnt = 2'd1;
                    starve_d  = '0;
                end else begin
                    underrun_d = 1'b1;
                    if (starve_q == C_STARVE_LAST) begin
                        cur_d[0] = '0;
                        cur_d[1] = '0;
                        starve_d = '0;
                        state_d  = ST_IDLE;
                    end else begin
                        starve_d = starve_q + 1'b1;
                    end
                end
            end
        end
        count_d       = count_q + (FIFO_LOG2 + 1)'(w_push) - (FIFO_LOG2 + 1)'(w_pop_cnt);
        wr_ptr_d      = wr_ptr_q + FIFO_LOG2'(w_push);
        rd_ptr_d      = rd_ptr_q + FIFO_LOG2'(w_pop_cnt);
        phase_d       = phase_q + 1'b1;
        tick_pend_d   = w_wrap;
        sample_tick_d = tick_pend_q;
    end

    // Per-channel interpolation; the result always lies between prev and cur,
    // so the low 16 bits of the sum are exact.
    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic signed [16:0]             w_diff;
        logic signed [16+PERIOD_LOG2:0] w_prod;
        logic signed [16+PERIOD_LOG2:0] w_step;
        logic                           w_unused;

        assign w_diff   = {cur_q[ch][15], cur_q[ch]} - {prev_q[ch][15], prev_q[ch]};
        assign w_prod   = $signed({{PERIOD_LOG2{w_diff[16]}}, w_diff})
                        * $signed({17'b0, phase_q});
        assign w_step   = w_prod >>> PERIOD_LOG2;
        assign w_unused = ^w_step[16+PERIOD_LOG2:16];
        assign dout_d[ch] = (prev_q[ch] + w_step[15:0]) ^ 16'h8000;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            phase_q       <= '0;
            state_q       <= ST_IDLE;
            starve_q      <= '0;
            for (int ch = 0; ch < 2; ch++) begin
                prev_q[ch] <= '0;
                cur_q[ch]  <= '0;
                dout_q[ch] <= 16'h8000;
            end
            tick_pend_q   <= 1'b0;
            sample_tick_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            phase_q       <= phase_d;
            state_q       <= state_d;
            starve_q      <= starve_d;
            prev_q        <= prev_d;
            cur_q         <= cur_d;
            dout_q        <= dout_d;
            tick_pend_q   <= tick_pend_d;
            sample_tick_q <= sample_tick_d;
            underrun_q    <= underrun_d;
        end
    end

    assign d_l         = dout_q[0];
    assign d_r         = dout_q[1];
    assign sample_tick = sample_tick_q;
    assign underrun    = underrun_q;

endmodule
`default_nettype wire
